// File: rtl/ila_capture_core_if.sv
// ----------------------------------------------------------------------------
// ila_capture_core_if
//   Readout stream between the ILA capture core and its sink.
//   rd_valid / rd_ready handshake, rd_data sample word, rd_last on the final
//   sample of a capture.
//   master : the capture core (drives valid/data/last, receives ready)
//   slave  : the readout sink  (drives ready, receives valid/data/last)
// ----------------------------------------------------------------------------
interface ila_capture_core_if #(
  parameter int SW = 64
) ();
  logic          rd_valid;
  logic          rd_ready;
  logic [SW-1:0] rd_data;
  logic          rd_last;

  modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/ila_capture_core.sv
// ----------------------------------------------------------------------------
// ila_capture_core
//   In-fabric logic-analyser capture engine. Registers NUM_PROBES packed probe
//   channels every cycle, stores them in a circular buffer, triggers on a
//   masked level or rising-edge compare, keeps a pre-trigger window chosen at
//   arm time, then streams the DEPTH captured samples out oldest first.
//
//   Ports
//     clk, rst    clock; asynchronous active-high reset
//     probe_in    packed probes, channel k at [k*PROBE_W +: PROBE_W]
//     arm         1-cycle pulse, starts a capture from IDLE only
//     abort       return to IDLE from any state (beats arm)
//     trig_mask   1 = bit takes part in the trigger compare
//     trig_value  trigger compare value
//     trig_mode   0 = level match, 1 = rising edge of match
//     pre_trig    pre-trigger sample count, sampled on arm
//     busy        capture in progress (PRE/WAIT/POST)
//     triggered   trigger seen in the current capture
//     done        buffer full and readable (DONE/READ)
//     trig_addr   buffer address of the trigger sample
//     rd          readout stream (valid/ready, data, last)
// ----------------------------------------------------------------------------
module ila_capture_core #(
  parameter  int NUM_PROBES = 8,
  parameter  int PROBE_W    = 8,
  parameter  int DEPTH      = 1024,
  parameter  int AW         = 10,
  localparam int SW         = NUM_PROBES * PROBE_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SW-1:0]             probe_in,
  input  logic                      arm,
  input  logic                      abort,
  input  logic [SW-1:0]             trig_mask,
  input  logic [SW-1:0]             trig_value,
  input  logic                      trig_mode,
  input  logic [AW-1:0]             pre_trig,
  output logic                      busy,
  output logic                      triggered,
  output logic                      done,
  output logic [AW-1:0]             trig_addr,
  ila_capture_core_if.master        rd
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_READ = 3'd5;

  // Counters carry one extra bit so a full DEPTH-1 window never wraps them.
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  logic [2:0]    state;
  logic [SW-1:0] s_q;
  logic          match;
  logic          match_d;
  logic          hit;
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_inc;
  logic [AW-1:0] pt;
  logic [AW:0]   post_n;
  logic          we;

  logic [SW-1:0] mem [DEPTH];

  // The same registered word feeds both the store and the compare, so the
  // sample flagged as the trigger is exactly the one written at trig_addr.
  assign match   = &(~(s_q ^ trig_value) | ~trig_mask);
  assign hit     = trig_mode ? (match & ~match_d) : match;
  assign cnt_inc = cnt + CNT_ONE;
  // pre_trig is AW bits wide, so it can never exceed DEPTH-1: the clamp of
  // the pre-trigger window to DEPTH-1 is implicit in the port width.
  assign post_n  = CNT_LAST - {1'b0, pt};

  assign busy = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
  assign done = (state == S_DONE) || (state == S_READ);
  assign we   = busy;

  // NOTE: the sample buffer has no reset; clearing it would block RAM
  // inference, and stale contents are never streamed out before being
  // overwritten by a full capture.
  always_ff @(posedge clk) begin
    if (we) mem[wp] <= s_q;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register in this block sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      s_q         <= '0;
      match_d     <= 1'b0;
      wp          <= '0;
      rp          <= '0;
      cnt         <= '0;
      pt          <= '0;
      triggered   <= 1'b0;
      trig_addr   <= '0;
      rd.rd_valid <= 1'b0;
      rd.rd_data  <= '0;
      rd.rd_last  <= 1'b0;
    end else begin
      s_q     <= probe_in;
      match_d <= match;
      if (abort) begin
        state       <= S_IDLE;
        rd.rd_valid <= 1'b0;
        rd.rd_last  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (arm) begin
              wp        <= '0;
              cnt       <= '0;
              triggered <= 1'b0;
              pt        <= pre_trig;
              state     <= (pre_trig == '0) ? S_WAIT : S_PRE;
            end
          end
          S_PRE: begin
            wp  <= wp + ADDR_ONE;
            cnt <= cnt_inc;
            if (cnt_inc == {1'b0, pt}) state <= S_WAIT;
          end
          S_WAIT: begin
            wp <= wp + ADDR_ONE;
            if (hit) begin
              trig_addr <= wp;
              triggered <= 1'b1;
              cnt       <= '0;
              state     <= (post_n == '0) ? S_DONE : S_POST;
            end
          end
          S_POST: begin
            wp  <= wp + ADDR_ONE;
            cnt <= cnt_inc;
            if (cnt_inc == post_n) state <= S_DONE;
          end
          S_DONE: begin
            rp    <= trig_addr - pt;
            cnt   <= '0;
            state <= S_READ;
          end
          S_READ: begin
            if (rd.rd_valid && rd.rd_ready && rd.rd_last) begin
              state       <= S_IDLE;
              rd.rd_valid <= 1'b0;
              rd.rd_last  <= 1'b0;
            end else if (!rd.rd_valid || rd.rd_ready) begin
              // Output register doubles as the RAM read register; it only
              // advances when empty or accepted, so it holds under stall.
              rd.rd_data  <= mem[rp];
              rd.rd_last  <= (cnt == CNT_LAST);
              rd.rd_valid <= 1'b1;
              rp          <= rp + ADDR_ONE;
              cnt         <= cnt_inc;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ila_capture_core.sv
// ----------------------------------------------------------------------------
// tb_ila_capture_core
//   Scoreboard bench for ila_capture_core at DEPTH=16, two 4-bit probes.
//   Each capture is described by a probe sequence; a reference model finds the
//   trigger sample from the trigger rules and queues the DEPTH expected
//   readout words. A separate monitor pops and compares on every handshake
//   and checks that data holds while the sink stalls.
// ----------------------------------------------------------------------------
module tb_ila_capture_core;
  localparam int NP    = 2;
  localparam int PW    = 4;
  localparam int SW    = NP * PW;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef struct packed {
    logic [SW-1:0] data;
    logic          last;
    logic [AW-1:0] taddr;
  } beat_t;

  logic          clk;
  logic          rst;
  logic [SW-1:0] probe_in;
  logic          arm;
  logic          abort;
  logic [SW-1:0] trig_mask;
  logic [SW-1:0] trig_value;
  logic          trig_mode;
  logic [AW-1:0] pre_trig;
  logic          busy;
  logic          triggered;
  logic          done;
  logic [AW-1:0] trig_addr;

  int            total;
  int            bad;
  int            ready_mode;
  logic [SW-1:0] seq[$];
  beat_t         exp_q[$];

  ila_capture_core_if #(.SW(SW)) rd_if ();

  ila_capture_core #(
    .NUM_PROBES(NP), .PROBE_W(PW), .DEPTH(DEPTH), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .probe_in(probe_in), .arm(arm), .abort(abort),
    .trig_mask(trig_mask), .trig_value(trig_value), .trig_mode(trig_mode),
    .pre_trig(pre_trig), .busy(busy), .triggered(triggered), .done(done),
    .trig_addr(trig_addr), .rd(rd_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Sink ready pattern: 0 never, 1 toggle, 2 always, 3 random.
  initial begin
    rd_if.rd_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       rd_if.rd_ready = 1'b0;
        1:       rd_if.rd_ready = ~rd_if.rd_ready;
        2:       rd_if.rd_ready = 1'b1;
        default: rd_if.rd_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compare every accepted beat against the scoreboard queue.
  initial begin
    logic          held_v;
    logic [SW-1:0] held_d;
    logic          held_l;
    beat_t         b;
    held_v = 1'b0;
    held_d = '0;
    held_l = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (held_v && rd_if.rd_valid) begin
        check("stall_hold_data", 32'(rd_if.rd_data), 32'(held_d));
        check("stall_hold_last", 32'(rd_if.rd_last), 32'(held_l));
      end
      held_v = rd_if.rd_valid && !rd_if.rd_ready;
      held_d = rd_if.rd_data;
      held_l = rd_if.rd_last;
      if (rd_if.rd_valid && rd_if.rd_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got data %0h, expected no beat", rd_if.rd_data);
        end else begin
          b = exp_q.pop_front();
          check("rd_data", 32'(rd_if.rd_data), 32'(b.data));
          check("rd_last", 32'(rd_if.rd_last), 32'(b.last));
          check("trig_addr", 32'(trig_addr), 32'(b.taddr));
          check("triggered_read", 32'(triggered), 32'd1);
        end
      end
    end
  end

  // Reference model: sample k of a capture is seq[k+1] (seq[1] is on the
  // probes at the arm edge); the match before sample 0 comes from seq[0].
  // WAIT starts at sample pt, so the trigger is the first hit at k >= pt.
  function automatic int find_trig(input int pt, input bit mode,
                                   input logic [SW-1:0] mask, input logic [SW-1:0] value);
    for (int k = pt; k + 1 < seq.size(); k++) begin
      bit m  = ((seq[k+1] ^ value) & mask) == '0;
      bit mp = ((seq[k]   ^ value) & mask) == '0;
      if (mode ? (m && !mp) : m) return k;
    end
    return -1;
  endfunction

  // kill: 0 normal, 1 abort at cycle kill_j, 2 abort once readout starts,
  // 3 reset pulse at cycle kill_j.
  task automatic run_capture(input int pt, input bit mode, input logic [SW-1:0] mask,
                             input logic [SW-1:0] value, input int rmode,
                             input int kill, input int kill_j);
    int kt;
    int post;
    int c;
    kt   = find_trig(pt, mode, mask, value);
    post = DEPTH - 1 - pt;
    if (kill == 0 || kill == 2) begin
      if (kt < 0 || kt + post + 2 > seq.size()) begin
        total++;
        bad++;
        $display("FAIL model_setup: trigger index %0d, expected one inside the sequence", kt);
        return;
      end
    end
    if (kill == 0) begin
      for (int i = 0; i < DEPTH; i++)
        exp_q.push_back('{data: seq[kt - pt + 1 + i], last: (i == DEPTH - 1), taddr: AW'(kt)});
    end
    ready_mode = rmode;
    trig_mask  = mask;
    trig_value = value;
    trig_mode  = mode;
    pre_trig   = AW'(pt);
    for (int j = 0; j < seq.size(); j++) begin
      @(negedge clk);
      probe_in = seq[j];
      arm      = (j == 1);
      abort    = (kill == 1 && j == kill_j);
      if (j == 2) begin
        #3;
        check("busy_after_arm", 32'(busy), 32'd1);
        check("triggered_cleared_on_arm", 32'(triggered), 32'd0);
      end
      if (kill == 3 && j == kill_j) begin
        #2;
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_triggered", 32'(triggered), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_trig_addr", 32'(trig_addr), 32'd0);
        check("rst_rd_valid", 32'(rd_if.rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_if.rd_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        arm = 1'b0;
        return;
      end
      if (kill == 1 && j == kill_j + 1) begin
        #3;
        check("abort_post_busy", 32'(busy), 32'd0);
        check("abort_post_done", 32'(done), 32'd0);
        check("abort_post_rd_valid", 32'(rd_if.rd_valid), 32'd0);
        check("abort_keeps_triggered", 32'(triggered), 32'd1);
        return;
      end
    end
    arm = 1'b0;
    if (kill == 2) begin
      c = 0;
      while (c < 100 && !rd_if.rd_valid) begin
        @(negedge clk);
        #3;
        c++;
      end
      check("read_started", 32'(rd_if.rd_valid), 32'd1);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #3;
      check("abort_read_rd_valid", 32'(rd_if.rd_valid), 32'd0);
      check("abort_read_done", 32'(done), 32'd0);
      check("abort_read_busy", 32'(busy), 32'd0);
      return;
    end
    c = 0;
    while (c < 400 && exp_q.size() != 0) begin
      @(negedge clk);
      probe_in = SW'($urandom);
      c++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL readout_timeout: %0d beats outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    #3;
    check("idle_done", 32'(done), 32'd0);
    check("idle_rd_valid", 32'(rd_if.rd_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic build_random(input int pt, input logic [SW-1:0] mask, input logic [SW-1:0] value);
    int            n;
    logic [SW-1:0] x;
    logic [SW-1:0] lowbit;
    seq.delete();
    n = pt + 1 + $urandom_range(0, 20);
    for (int j = 0; j <= n; j++) begin
      x = SW'($urandom);
      if ($urandom_range(0, 3) == 0) x = (x & ~mask) | (value & mask);
      seq.push_back(x);
    end
    // Guarantee a rising match at sample n-1 (>= pt) for either mode.
    lowbit     = mask & ((~mask) + SW'(1));
    seq[n]     = (seq[n] & ~mask) | (value & mask);
    seq[n - 1] = ((seq[n - 1] & ~mask) | (value & mask)) ^ lowbit;
    for (int j = 0; j < DEPTH + 2; j++) seq.push_back(SW'($urandom));
  endtask

  function automatic logic [SW-1:0] avoid(input logic [SW-1:0] x, input logic [SW-1:0] v);
    return (x == v) ? (x ^ SW'(1)) : x;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [SW-1:0] mask;
    logic [SW-1:0] value;
    total      = 0;
    bad        = 0;
    ready_mode = 2;
    rst        = 1'b1;
    arm        = 1'b0;
    abort      = 1'b0;
    probe_in   = '0;
    trig_mask  = '0;
    trig_value = '0;
    trig_mode  = 1'b0;
    pre_trig   = '0;
    #2;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_triggered", 32'(triggered), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_trig_addr", 32'(trig_addr), 32'd0);
    check("reset_rd_valid", 32'(rd_if.rd_valid), 32'd0);
    check("reset_rd_last", 32'(rd_if.rd_last), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Ramp, pt=4, level on 20: readout 16..31, trigger address 19 mod 16.
    seq.delete();
    for (int j = 0; j < 40; j++) seq.push_back(SW'(j));
    run_capture(4, 1'b0, 8'hFF, 8'd20, 2, 0, 0);

    // pt=0 with a match on the very first WAIT sample.
    seq.delete();
    seq.push_back(8'h00);
    seq.push_back(8'hA5);
    for (int j = 0; j < 20; j++) seq.push_back(SW'($urandom));
    run_capture(0, 1'b0, 8'hFF, 8'hA5, 2, 0, 0);

    // Maximum pre-trigger window: trigger word is the last one read out.
    seq.delete();
    for (int j = 0; j < 30; j++) seq.push_back(avoid(SW'($urandom), 8'h3C));
    seq[20] = 8'h3C;
    run_capture(DEPTH - 1, 1'b0, 8'hFF, 8'h3C, 3, 0, 0);

    // Edge mode, match held for 10 samples: one trigger at the first.
    seq.delete();
    for (int j = 0; j < 40; j++) seq.push_back({4'($urandom), ((j >= 10 && j < 20) ? 4'h5 : 4'hA)});
    run_capture(3, 1'b1, 8'h0F, 8'h05, 2, 0, 0);

    // Match during PRE is ignored; the later match in WAIT triggers.
    seq.delete();
    for (int j = 0; j < 40; j++) seq.push_back(avoid(SW'($urandom), 8'h77));
    seq[3]  = 8'h77;
    seq[12] = 8'h77;
    run_capture(6, 1'b0, 8'hFF, 8'h77, 2, 0, 0);

    // Sink toggling ready every cycle.
    build_random(5, 8'hF0, 8'h90);
    run_capture(5, 1'b0, 8'hF0, 8'h90, 1, 0, 0);

    // Abort while in POST, then abort once readout is under way.
    seq.delete();
    for (int j = 0; j < 40; j++) seq.push_back(SW'(j));
    run_capture(2, 1'b0, 8'hFF, 8'd10, 2, 1, 13);
    run_capture(1, 1'b0, 8'hFF, 8'd5, 0, 2, 0);

    // A fresh arm after the aborts captures normally.
    build_random(7, 8'h3C, 8'h14);
    run_capture(7, 1'b1, 8'h3C, 8'h14, 2, 0, 0);

    // Reset pulse while waiting for a trigger that never comes.
    seq.delete();
    for (int j = 0; j < 30; j++) seq.push_back(SW'(j));
    run_capture(2, 1'b0, 8'hFF, 8'hFF, 2, 3, 8);

    for (int r = 0; r < 8; r++) begin
      int pt;
      bit mode;
      pt    = $urandom_range(0, DEPTH - 1);
      mode  = 1'($urandom_range(0, 1));
      mask  = SW'($urandom) | (SW'(1) << $urandom_range(0, SW - 1));
      value = SW'($urandom);
      build_random(pt, mask, value);
      run_capture(pt, mode, mask, value, $urandom_range(1, 3), 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
